bitvec_wb_ctrl: RTL and testbench

- Write-back controller for filter bit-vector results.
- Accepts 64-bit result words from the scan datapath and packs WORDS_PER_CL words into one 512-bit line.
- Issues one-line memory write requests on the CCI-P c1 channel to consecutive lines from a software-supplied base.
- Throttles on c1 almost-full and an outstanding-write credit limit; reports completion once every write is acknowledged.

---
 rtl/bitvec_wb_pkg.sv | 25 ++
 rtl/bitvec_wb_ctrl_if.sv | 32 +++
 rtl/bitvec_line_packer.sv | 48 ++++
 rtl/bitvec_wb_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_bitvec_wb_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitvec_wb_pkg.sv
// Shared types and constants for the bit-vector write-back controller.
// Holds the FSM state enum, word/line widths, the cache-line payload type
// and the bit offsets of the fields in the optional status line.
package bitvec_wb_pkg;

  localparam int unsigned WORD_BITS = 64;
  localparam int unsigned CL_BITS   = 512;

  typedef logic [CL_BITS-1:0] t_cl_line;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ISSUE,
    ISSUE_STATUS,
    DRAIN,
    DONE
  } t_wb_state;

  // Status line layout: total word count, data line count, marker bit.
  localparam int unsigned STAT_TOTAL_LSB = 0;
  localparam int unsigned STAT_LINES_LSB = 64;
  localparam int unsigned STAT_FLAG_BIT  = CL_BITS - 1;

endpackage

// File: rtl/bitvec_wb_ctrl_if.sv
// Result-stream and CCI-P c1 write channel bundle of bitvec_wb_ctrl.
//   res_valid/res_data/res_ready : 64-bit result word stream into the controller
//   c1_almfull                   : c1 Tx almost-full back-pressure
//   wr_valid/wr_addr/wr_data     : one-line write request (one cycle per line)
//   wr_rsp_valid                 : one write acknowledgement
// master = the controller, slave = the datapath/memory side.
interface bitvec_wb_ctrl_if
  import bitvec_wb_pkg::*;
#(
  parameter int unsigned CL_ADDR_W = 42
);

  logic                 res_valid;
  logic [WORD_BITS-1:0] res_data;
  logic                 res_ready;
  logic                 c1_almfull;
  logic                 wr_valid;
  logic [CL_ADDR_W-1:0] wr_addr;
  t_cl_line             wr_data;
  logic                 wr_rsp_valid;

  modport master (
    input  res_valid, res_data, c1_almfull, wr_rsp_valid,
    output res_ready, wr_valid, wr_addr, wr_data
  );

  modport slave (
    output res_valid, res_data, c1_almfull, wr_rsp_valid,
    input  res_ready, wr_valid, wr_addr, wr_data
  );

endinterface

// File: rtl/bitvec_line_packer.sv
// Packs 64-bit result words into one 512-bit staging line.
//   clk, reset : clock, synchronous active-high reset
//   clear      : discard the staging line (zeroes data, index, full)
//   wr_en      : accept word_in into slot word_idx
//   flush      : with wr_en, mark the line complete even if slots remain
//   word_in    : result word
//   line       : staging line, word k at bits [64*k +: 64], unused slots 0
//   word_idx   : next free slot
//   full       : line complete (all slots written or flushed)
module bitvec_line_packer
  import bitvec_wb_pkg::*;
#(
  parameter int unsigned WORDS_PER_CL = 8,
  localparam int unsigned IDX_W = (WORDS_PER_CL > 1) ? $clog2(WORDS_PER_CL) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic                 flush,
  input  logic [WORD_BITS-1:0] word_in,
  output t_cl_line             line,
  output logic [IDX_W-1:0]     word_idx,
  output logic                 full
);

  logic last_slot_c;

  assign last_slot_c = (word_idx == IDX_W'(WORDS_PER_CL - 1));

  // Staging line accumulator; clear wins over a write.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      line     <= '0;
      word_idx <= '0;
      full     <= 1'b0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < WORDS_PER_CL; k++) begin
        if (word_idx == IDX_W'(k)) begin
          line[k*WORD_BITS +: WORD_BITS] <= word_in;
        end
      end
      word_idx <= last_slot_c ? '0 : word_idx + IDX_W'(1);
      full     <= last_slot_c || flush;
    end
  end

endmodule

// File: rtl/bitvec_wb_ctrl.sv
// Write-back controller for filter bit-vector results.
// Packs WORDS_PER_CL result words per 512-bit line and writes the lines to
// consecutive cache lines from base_addr on the CCI-P c1 channel, throttled by
// c1_almfull and an outstanding-write credit limit. done is raised once every
// write has been acknowledged and is held until the next start.
// Optional build macro BITVEC_WB_STATUS_LINE_EN: after the last data line one
// extra status line (total_words, data lines written, marker bit 511) is
// written to the next line address; it uses a credit but is not counted in
// lines_written.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : one-cycle pulse, latches base_addr/total_words
//   base_addr             : first destination line address
//   total_words           : number of result words expected
//   bus (master)          : result stream in, c1 write requests/acks
//   busy                  : job in progress (start accepted, not yet done)
//   done                  : all lines written and acknowledged
//   lines_written         : data lines issued since start
//   outstanding           : writes in flight
module bitvec_wb_ctrl
  import bitvec_wb_pkg::*;
#(
  parameter int unsigned CL_ADDR_W       = 42,
  parameter int unsigned WORDS_PER_CL    = 8,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_W           = 16,
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CL_ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]     total_words,
  bitvec_wb_ctrl_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     lines_written,
  output logic [OUT_W-1:0]     outstanding
);

  localparam int unsigned IDX_W = (WORDS_PER_CL > 1) ? $clog2(WORDS_PER_CL) : 1;

  t_wb_state            state;
  logic [CL_ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]     words_left;
  logic [CNT_W-1:0]     line_idx;

  t_cl_line             pk_line;
  logic [IDX_W-1:0]     pk_word_idx;
  logic                 pk_full;

  logic word_hs_c;
  logic last_word_c;
  logic line_done_c;
  logic start_take_c;
  logic credit_ok_c;
  logic issue_fire_c;
  logic ack_take_c;

  assign word_hs_c    = bus.res_valid && bus.res_ready;
  assign last_word_c  = (words_left == CNT_W'(1));
  assign line_done_c  = (pk_word_idx == IDX_W'(WORDS_PER_CL - 1)) || last_word_c;
  assign start_take_c = start && ((state == IDLE) || (state == DONE));

  // The !wr_valid term keeps requests at least one cycle apart, which matters
  // when the status line follows the last data line directly.
  assign credit_ok_c = !bus.c1_almfull && !bus.wr_valid &&
                       (outstanding < OUT_W'(MAX_OUTSTANDING));

  // Acks with nothing in flight (e.g. stragglers after reset) are dropped.
  assign ack_take_c = bus.wr_rsp_valid && (outstanding != '0);

  // A write request leaves this cycle.
  always_comb begin
    issue_fire_c = 1'b0;
    case (state)
      ISSUE:        issue_fire_c = credit_ok_c && pk_full;
      ISSUE_STATUS: issue_fire_c = credit_ok_c;
      default:      issue_fire_c = 1'b0;
    endcase
  end

  bitvec_line_packer #(
    .WORDS_PER_CL (WORDS_PER_CL)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_take_c || issue_fire_c),
    .wr_en    (word_hs_c),
    .flush    (word_hs_c && last_word_c),
    .word_in  (bus.res_data),
    .line     (pk_line),
    .word_idx (pk_word_idx),
    .full     (pk_full)
  );

`ifdef BITVEC_WB_STATUS_LINE_EN
  logic [CNT_W-1:0] total_q;
  t_cl_line         status_line_c;

  // Trailer line describing the completed job.
  always_comb begin
    status_line_c = '0;
    status_line_c[STAT_TOTAL_LSB +: CNT_W] = total_q;
    status_line_c[STAT_LINES_LSB +: CNT_W] = lines_written;
    status_line_c[STAT_FLAG_BIT]           = 1'b1;
  end
`endif

  // Job FSM with registered outputs, credit counter and line addressing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      base_q        <= '0;
      words_left    <= '0;
      line_idx      <= '0;
      lines_written <= '0;
      outstanding   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.res_ready <= 1'b0;
      bus.wr_valid  <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
`ifdef BITVEC_WB_STATUS_LINE_EN
      total_q       <= '0;
`endif
    end else begin
      bus.wr_valid <= 1'b0;
      outstanding  <= outstanding + OUT_W'(issue_fire_c) - OUT_W'(ack_take_c);

      case (state)
        IDLE, DONE: begin
          if (start_take_c) begin
            base_q        <= base_addr;
            words_left    <= total_words;
            line_idx      <= '0;
            lines_written <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
`ifdef BITVEC_WB_STATUS_LINE_EN
            total_q       <= total_words;
`endif
            // An empty job has nothing to fill; never raise res_ready.
            if (total_words == '0) begin
              state <= DRAIN;
            end else begin
              state         <= FILL;
              bus.res_ready <= 1'b1;
            end
          end
        end

        FILL: begin
          if (word_hs_c) begin
            words_left <= words_left - CNT_W'(1);
            if (line_done_c) begin
              state         <= ISSUE;
              bus.res_ready <= 1'b0;
            end
          end
        end

        ISSUE: begin
          if (issue_fire_c) begin
            bus.wr_valid  <= 1'b1;
            bus.wr_addr   <= base_q + CL_ADDR_W'(line_idx);
            bus.wr_data   <= pk_line;
            line_idx      <= line_idx + CNT_W'(1);
            lines_written <= lines_written + CNT_W'(1);
            if (words_left != '0) begin
              state         <= FILL;
              bus.res_ready <= 1'b1;
            end else begin
`ifdef BITVEC_WB_STATUS_LINE_EN
              state <= ISSUE_STATUS;
`else
              state <= DRAIN;
`endif
            end
          end
        end

`ifdef BITVEC_WB_STATUS_LINE_EN
        ISSUE_STATUS: begin
          if (issue_fire_c) begin
            bus.wr_valid <= 1'b1;
            bus.wr_addr  <= base_q + CL_ADDR_W'(line_idx);
            bus.wr_data  <= status_line_c;
            state        <= DRAIN;
          end
        end
`endif

        DRAIN: begin
          if (outstanding == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitvec_wb_ctrl.sv
// Self-checking bench for bitvec_wb_ctrl: table of jobs plus randomized jobs
// scored against a line-level reference (expected write queue, credit count),
// and hand-written sequences for credit stall, almost-full stall and reset.
module tb_bitvec_wb_ctrl;
  import bitvec_wb_pkg::*;

  localparam int unsigned AW   = 42;
  localparam int unsigned WPC  = 8;
  localparam int unsigned MAXO = 2;
  localparam int unsigned CW   = 16;
  localparam int unsigned OW   = $clog2(MAXO) + 1;
  localparam int          MAXW = 64;
`ifdef BITVEC_WB_STATUS_LINE_EN
  localparam int STATUS_EN = 1;
`else
  localparam int STATUS_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] total_words;
  logic          busy;
  logic          done;
  logic [CW-1:0] lines_written;
  logic [OW-1:0] outstanding;

  bitvec_wb_ctrl_if #(.CL_ADDR_W(AW)) bus ();

  bitvec_wb_ctrl #(
    .CL_ADDR_W       (AW),
    .WORDS_PER_CL    (WPC),
    .MAX_OUTSTANDING (MAXO),
    .CNT_W           (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .total_words   (total_words),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .lines_written (lines_written),
    .outstanding   (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    int            total;
    bit            seq;
    int            vpct;
    int            kpct;
    int            apct;
    bit            poke;
    int            exp_lines;
  } t_vec;

  int n_cmp, n_err;
  int sent, cur_total, writes_seen, model_out, cyc;
  bit prev_wv;
  logic [63:0]   words [MAXW];
  logic [AW-1:0] exp_addr_q [$];
  t_cl_line      exp_data_q [$];
  t_vec          vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_line(input string nm, input t_cl_line act, input t_cl_line exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // One clock: sample DUT 1 time unit after the edge, score writes and credits.
  task automatic tick();
    bit hs, ack_in, rst_in;
    logic [AW-1:0] ea;
    t_cl_line ed;
    hs     = bus.res_valid && bus.res_ready;
    ack_in = bus.wr_rsp_valid;
    rst_in = reset;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_in) begin
      model_out = 0;
      exp_addr_q.delete();
      exp_data_q.delete();
    end else begin
      if (hs) sent++;
      if (bus.wr_valid) begin
        writes_seen++;
        chk("wr_valid_gap", 64'(prev_wv), 64'd0);
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got write to %0h, required none", bus.wr_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          chk("wr_addr", 64'(bus.wr_addr), 64'(ea));
          chk_line("wr_data", bus.wr_data, ed);
        end
      end
      model_out = model_out + (bus.wr_valid ? 1 : 0) - ((ack_in && model_out > 0) ? 1 : 0);
    end
    chk("outstanding", 64'(outstanding), 64'(model_out));
    prev_wv = bus.wr_valid;
  endtask

  task automatic drive_cycle(input bit want_valid, input bit almf, input bit ack);
    bus.res_valid    = want_valid && (sent < cur_total);
    bus.res_data     = (sent < cur_total && sent < MAXW) ? words[sent] : 64'hdead_beef_dead_beef;
    bus.c1_almfull   = almf;
    bus.wr_rsp_valid = ack;
    tick();
  endtask

  // Build the expected line writes for a job and pulse start.
  task automatic start_job(input logic [AW-1:0] base, input int total, input bit seq);
    int nl, idx;
    t_cl_line ln;
    cur_total = total;
    sent = 0;
    writes_seen = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < MAXW; i++) words[i] = seq ? 64'(i) : {$urandom, $urandom};
    nl = (total + WPC - 1) / WPC;
    for (int l = 0; l < nl; l++) begin
      ln = '0;
      for (int w = 0; w < WPC; w++) begin
        idx = l * WPC + w;
        if (idx < total) ln[64*w +: 64] = words[idx];
      end
      exp_addr_q.push_back(base + AW'(l));
      exp_data_q.push_back(ln);
    end
    if (STATUS_EN != 0 && total > 0) begin
      ln = '0;
      ln[CW-1:0]  = CW'(total);
      ln[64 +: CW] = CW'(nl);
      ln[511]     = 1'b1;
      exp_addr_q.push_back(base + AW'(nl));
      exp_data_q.push_back(ln);
    end
    start       = 1'b1;
    base_addr   = base;
    total_words = CW'(total);
    drive_cycle(0, 0, 0);
    start = 1'b0;
  endtask

  task automatic drain_job(input int vpct, input int kpct, input int apct,
                           input bit poke, input logic [AW-1:0] base);
    int n;
    bit poked;
    poked = 0;
    for (n = 0; n < 4000 && done !== 1'b1; n++) begin
      start = poke && !poked && sent >= 2 && sent < cur_total;
      if (start) begin
        poked       = 1;
        base_addr   = ~base;
        total_words = CW'(7);
      end
      drive_cycle($urandom_range(99) < vpct, $urandom_range(99) < apct,
                  model_out > 0 && $urandom_range(99) < kpct);
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL job_timeout: done=%0d after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic end_checks(input int exp_lines, input int total);
    int exp_writes;
    exp_writes = exp_lines + ((STATUS_EN != 0 && total > 0) ? 1 : 0);
    chk("done", 64'(done), 64'd1);
    chk("busy", 64'(busy), 64'd0);
    chk("lines_written", 64'(lines_written), 64'(exp_lines));
    chk("outstanding_end", 64'(outstanding), 64'd0);
    chk("writes_seen", 64'(writes_seen), 64'(exp_writes));
    chk("words_sent", 64'(sent), 64'(total));
    chk("exp_queue_left", 64'(exp_addr_q.size()), 64'd0);
    repeat (3) drive_cycle(0, 0, 0);
    chk("done_held", 64'(done), 64'd1);
  endtask

  initial begin
    t_vec v;
    n_cmp = 0; n_err = 0; sent = 0; cur_total = 0; writes_seen = 0;
    model_out = 0; cyc = 0; prev_wv = 0;
    reset = 1'b1; start = 1'b0; base_addr = '0; total_words = '0;
    bus.res_valid = 1'b0; bus.res_data = '0; bus.c1_almfull = 1'b0; bus.wr_rsp_valid = 1'b0;

    //            base               total seq vpct kpct apct poke lines
    vecs[0] = '{42'h1000,             16,  1,  100, 100, 0,   0,   2};
    vecs[1] = '{42'h1000,             3,   1,  100, 100, 0,   0,   1};
    vecs[2] = '{42'h55,               0,   0,  100, 100, 0,   0,   0};
    vecs[3] = '{42'h3FF_FFFF_FFFE,    20,  0,  70,  60,  20,  1,   3};
    vecs[4] = '{42'h2000,             8,   0,  50,  30,  30,  0,   1};
    vecs[5] = '{42'h7,                9,   0,  90,  80,  10,  1,   2};
    vecs[6] = '{42'hABCD,             40,  0,  80,  50,  25,  1,   5};
    vecs[7] = '{42'h100,              7,   1,  100, 10,  0,   0,   1};

    drive_cycle(0, 0, 0);
    drive_cycle(0, 0, 0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lines", 64'(lines_written), 64'd0);
    chk("rst_res_ready", 64'(bus.res_ready), 64'd0);
    chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk_line("rst_wr_data", bus.wr_data, '0);
    reset = 1'b0;
    drive_cycle(0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      start_job(vecs[i].base, vecs[i].total, vecs[i].seq);
      drain_job(vecs[i].vpct, vecs[i].kpct, vecs[i].apct, vecs[i].poke, vecs[i].base);
      end_checks(vecs[i].exp_lines, vecs[i].total);
    end

    for (int r = 0; r < 6; r++) begin
      v.base  = AW'({$urandom, $urandom});
      v.total = $urandom_range(40, 1);
      start_job(v.base, v.total, 0);
      drain_job($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(40), 1, v.base);
      end_checks((v.total + WPC - 1) / WPC, v.total);
    end

    // Credit limit: acks withheld, each single ack frees exactly one write.
    start_job(42'h3000, 32, 0);
    repeat (40) drive_cycle(1, 0, 0);
    chk("credit_writes", 64'(writes_seen), 64'd2);
    chk("credit_outstanding", 64'(outstanding), 64'd2);
    chk("credit_res_ready", 64'(bus.res_ready), 64'd0);
    drive_cycle(1, 0, 1);
    repeat (20) drive_cycle(1, 0, 0);
    chk("credit_one_ack_a", 64'(writes_seen), 64'd3);
    drive_cycle(1, 0, 1);
    repeat (20) drive_cycle(1, 0, 0);
    chk("credit_one_ack_b", 64'(writes_seen), 64'd4);
    drain_job(100, 100, 0, 0, 42'h3000);
    end_checks(4, 32);

    // Almost-full stall, then same-cycle issue and ack.
    start_job(42'h4000, 16, 1);
    for (int n = 0; n < 50 && sent < 8; n++) drive_cycle(1, 0, 0);
    drive_cycle(0, 0, 0);
    drive_cycle(0, 0, 0);
    chk("almf_first_write", 64'(writes_seen), 64'd1);
    for (int n = 0; n < 50 && sent < 16; n++) drive_cycle(1, 1, 0);
    repeat (10) drive_cycle(0, 1, 0);
    chk("almf_blocked", 64'(writes_seen), 64'd1);
    drive_cycle(0, 0, 1);
    chk("almf_release_wr_valid", 64'(bus.wr_valid), 64'd1);
    chk("issue_ack_same_cycle", 64'(outstanding), 64'd1);
    drain_job(100, 100, 0, 0, 42'h4000);
    end_checks(2, 16);

    // Reset after the first of two lines, then a late ack.
    start_job(42'h5000, 16, 0);
    for (int n = 0; n < 60 && writes_seen < 1; n++) drive_cycle(1, 0, 0);
    repeat (3) drive_cycle(1, 0, 0);
    chk("rst_mid_outstanding", 64'(outstanding), 64'd1);
    reset = 1'b1;
    drive_cycle(0, 0, 0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_lines", 64'(lines_written), 64'd0);
    chk("rst_mid_res_ready", 64'(bus.res_ready), 64'd0);
    chk("rst_mid_wr_valid", 64'(bus.wr_valid), 64'd0);
    chk("rst_mid_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk_line("rst_mid_wr_data", bus.wr_data, '0);
    reset = 1'b0;
    drive_cycle(0, 0, 1);
    chk("late_ack_outstanding", 64'(outstanding), 64'd0);
    drive_cycle(0, 0, 0);
    chk("late_ack_outstanding_b", 64'(outstanding), 64'd0);

    // Recovery after reset.
    start_job(42'h6000, 8, 1);
    drain_job(100, 100, 0, 0, 42'h6000);
    end_checks(1, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
